// File: rtl/RV_buffer_pkg.sv
// Shared definitions for the ready/valid buffer family: counter width helper,
// performance counter width and a common occupancy count type.
package RV_buffer_pkg;

  localparam int PERF_CNTW = 32;

  // Widest occupancy any buffer in this family is expected to report.
  localparam int OCC_MAXW = 16;

  typedef logic [OCC_MAXW-1:0] occ_t;

  // Bits needed to hold an occupancy of 0..depth; never returns 0.
  function automatic int cntw_f(input int depth);
    if (depth < 1) return 1;
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rv_ebuf_ctrl.sv
// Pointer, occupancy and flag control for rv_elastic_buffer.
// Define RV_EBUF_PERF_EN to build the saturating backpressure stall counter.
module rv_ebuf_ctrl
  import RV_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int CNTW      = cntw_f(DEPTH),
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic                 ready_out,
  output logic                 ready_in,
  output logic                 valid_out,
  output logic                 almost_full,
  output logic [CNTW-1:0]      count,
  output logic [PERF_CNTW-1:0] stall_cnt,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [AW-1:0]        rd_addr
);

  // Handshakes: push = valid_in && ready_in, pop = valid_out && ready_out.
  // Both flags are registered from the next occupancy, so a pop at full frees
  // a slot only on the following cycle and a push reaches the output one
  // cycle later (no same-cycle refill, no data bypass).
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] AF_C    = CNTW'(AF_THRESH);
  localparam logic            AF_RST  = (AF_THRESH == 0);

  logic            push;
  logic            pop;
  logic [CNTW-1:0] next_count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign push = valid_in && ready_in;
  assign pop  = valid_out && ready_out;

  always_comb begin
    next_count = count;
    if (push && !pop)
      next_count = count + CNTW'(1);
    else if (pop && !push)
      next_count = count - CNTW'(1);
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ready_in    <= 1'b1;
      valid_out   <= 1'b0;
      almost_full <= AF_RST;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count       <= next_count;
      ready_in    <= (next_count < DEPTH_C);
      valid_out   <= (next_count != '0);
      almost_full <= (next_count >= AF_C);
    end
  end

  // Data offered during a flush is dropped, not written.
  assign wr_en   = push && !flush && !reset;
  assign wr_addr = wr_ptr;
  assign rd_addr = rd_ptr;

`ifdef RV_EBUF_PERF_EN
  // Survives flush so stalls can be measured across pipeline kills.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (valid_out && !ready_out && (stall_cnt != '1))
      stall_cnt <= stall_cnt + PERF_CNTW'(1);
  end
`else
  assign stall_cnt = '0;
`endif

  count_bound_a: assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);

endmodule

// File: rtl/rv_elastic_buffer.sv
// DEPTH-entry ready/valid elastic buffer with registered flags and sync flush.
// Define RV_EBUF_PERF_EN to enable the stall_cnt performance counter.
module rv_elastic_buffer
  import RV_buffer_pkg::*;
#(
  parameter int DATAW     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int CNTW      = cntw_f(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [DATAW-1:0]     data_in,
  output logic                 ready_in,
  output logic                 valid_out,
  output logic [DATAW-1:0]     data_out,
  input  logic                 ready_out,
  output logic [CNTW-1:0]      count,
  output logic                 almost_full,
  output logic [PERF_CNTW-1:0] stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [DATAW-1:0] mem [DEPTH];

  rv_ebuf_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .CNTW      (CNTW),
    .AW        (AW)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .ready_in    (ready_in),
    .valid_out   (valid_out),
    .almost_full (almost_full),
    .count       (count),
    .stall_cnt   (stall_cnt),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr)
  );

  // Storage is deliberately unreset; data_out is meaningless while !valid_out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= data_in;
  end

  assign data_out = mem[rd_addr];

endmodule

// File: tb/tb_rv_elastic_buffer.sv
// Directed and randomized checks of rv_elastic_buffer (DEPTH=4/DATAW=8 and
// DEPTH=8/DATAW=16 instances).
module tb_rv_elastic_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        ready_in;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        ready_out;
  logic [2:0]  count;
  logic        almost_full;
  logic [31:0] stall_cnt;

  logic        flush8;
  logic        valid_in8;
  logic [15:0] data_in8;
  logic        ready_in8;
  logic        valid_out8;
  logic [15:0] data_out8;
  logic        ready_out8;
  logic [3:0]  count8;
  logic        almost_full8;
  logic [31:0] stall_cnt8;

  int total;
  int bad;

  logic [15:0] exp_q[$];

`ifdef RV_EBUF_PERF_EN
  localparam logic [31:0] STALL_EXP = 32'd10;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv_elastic_buffer #(.DATAW(8), .DEPTH(4)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_in    (ready_in),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .ready_out   (ready_out),
    .count       (count),
    .almost_full (almost_full),
    .stall_cnt   (stall_cnt)
  );

  rv_elastic_buffer #(.DATAW(16), .DEPTH(8)) u_dut8 (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush8),
    .valid_in    (valid_in8),
    .data_in     (data_in8),
    .ready_in    (ready_in8),
    .valid_out   (valid_out8),
    .data_out    (data_out8),
    .ready_out   (ready_out8),
    .count       (count8),
    .almost_full (almost_full8),
    .stall_cnt   (stall_cnt8)
  );

  // Advance one cycle; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL reset_ready_in got=%b exp=1", ready_in); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    total++; if (count8 !== 4'd0 || ready_in8 !== 1'b1 || valid_out8 !== 1'b0) begin
      bad++; $display("FAIL reset_dut8 count=%0d ready_in=%b valid_out=%b exp=0/1/0", count8, ready_in8, valid_out8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    ready_out = 1'b1;
    valid_in  = 1'b1;
    data_in   = 8'h01;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL b2b_no_bypass valid_out=%b exp=0", valid_out); end
    for (int i = 0; i < 8; i++) begin
      data_in = 8'(i + 1);
      step();
      exp_d = 8'(i + 1);
      total++; if (valid_out !== 1'b1 || data_out !== exp_d) begin
        bad++; $display("FAIL b2b_data[%0d] valid_out=%b data_out=%h exp=1/%h", i, valid_out, data_out, exp_d);
      end
      total++; if (count !== 3'd1 || ready_in !== 1'b1) begin
        bad++; $display("FAIL b2b_count[%0d] count=%0d ready_in=%b exp=1/1", i, count, ready_in);
      end
    end
    valid_in = 1'b0;
    step();
    total++; if (count !== 3'd0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL b2b_empty count=%0d valid_out=%b exp=0/0", count, valid_out);
    end
  endtask

  task automatic test_fill_hold();
    logic [2:0] exp_c;
    logic [7:0] drain_d [4];
    logic [2:0] drain_c [4];
    drain_d[0] = 8'hA1; drain_d[1] = 8'hA2; drain_d[2] = 8'hA3; drain_d[3] = 8'hA4;
    drain_c[0] = 3'd3;  drain_c[1] = 3'd3;  drain_c[2] = 3'd2;  drain_c[3] = 3'd1;
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      data_in  = 8'hA0 + 8'(i);
      step();
      exp_c = 3'(i + 1);
      total++; if (count !== exp_c) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, exp_c); end
      total++; if (almost_full !== (i >= 2)) begin bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i >= 2)); end
      total++; if (ready_in !== (i < 3)) begin bad++; $display("FAIL fill_ready_in[%0d] got=%b exp=%b", i, ready_in, (i < 3)); end
    end
    data_in = 8'hA4;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (count !== 3'd4 || ready_in !== 1'b0 || valid_out !== 1'b1 || data_out !== 8'hA0) begin
        bad++; $display("FAIL hold[%0d] count=%0d ready_in=%b valid_out=%b data_out=%h exp=4/0/1/a0", i, count, ready_in, valid_out, data_out);
      end
    end
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 1) valid_in = 1'b0;  // A4 taken on the second drain cycle
      total++; if (data_out !== drain_d[i] || count !== drain_c[i] || valid_out !== 1'b1) begin
        bad++; $display("FAIL drain[%0d] data_out=%h count=%0d valid_out=%b exp=%h/%0d/1", i, data_out, count, valid_out, drain_d[i], drain_c[i]);
      end
    end
    step();
    total++; if (count !== 3'd0 || valid_out !== 1'b0 || ready_in !== 1'b1) begin
      bad++; $display("FAIL drain_empty count=%0d valid_out=%b ready_in=%b exp=0/0/1", count, valid_out, ready_in);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'hB1; exp_d[1] = 8'hB2; exp_d[2] = 8'hB3; exp_d[3] = 8'hB4;
    ready_out = 1'b0;
    valid_in  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'hB0 + 8'(i);
      step();
    end
    total++; if (count !== 3'd4 || ready_in !== 1'b0) begin
      bad++; $display("FAIL fullpop_full count=%0d ready_in=%b exp=4/0", count, ready_in);
    end
    data_in   = 8'hB4;
    ready_out = 1'b1;
    step();
    ready_out = 1'b0;
    total++; if (count !== 3'd3 || ready_in !== 1'b1 || data_out !== 8'hB1) begin
      bad++; $display("FAIL fullpop_pop count=%0d ready_in=%b data_out=%h exp=3/1/b1", count, ready_in, data_out);
    end
    step();
    valid_in = 1'b0;
    total++; if (count !== 3'd4 || ready_in !== 1'b0) begin
      bad++; $display("FAIL fullpop_refill count=%0d ready_in=%b exp=4/0", count, ready_in);
    end
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (valid_out !== 1'b1 || data_out !== exp_d[i]) begin
        bad++; $display("FAIL wrap_order[%0d] valid_out=%b data_out=%h exp=1/%h", i, valid_out, data_out, exp_d[i]);
      end
      step();
    end
    ready_out = 1'b0;
    total++; if (count !== 3'd0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL wrap_empty count=%0d valid_out=%b exp=0/0", count, valid_out);
    end
  endtask

  task automatic test_flush();
    ready_out = 1'b0;
    valid_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'hC0 + 8'(i);
      step();
    end
    total++; if (count !== 3'd3 || almost_full !== 1'b1) begin
      bad++; $display("FAIL flush_pre count=%0d almost_full=%b exp=3/1", count, almost_full);
    end
    flush   = 1'b1;
    data_in = 8'h55;
    step();
    flush    = 1'b0;
    valid_in = 1'b0;
    total++; if (count !== 3'd0 || valid_out !== 1'b0 || ready_in !== 1'b1 || almost_full !== 1'b0) begin
      bad++; $display("FAIL flush_post count=%0d valid_out=%b ready_in=%b af=%b exp=0/0/1/0", count, valid_out, ready_in, almost_full);
    end
    step();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL flush_drop valid_out=%b exp=0", valid_out); end
    valid_in  = 1'b1;
    data_in   = 8'hD0;
    ready_out = 1'b1;
    step();
    valid_in = 1'b0;
    total++; if (valid_out !== 1'b1 || data_out !== 8'hD0 || count !== 3'd1) begin
      bad++; $display("FAIL flush_next valid_out=%b data_out=%h count=%0d exp=1/d0/1", valid_out, data_out, count);
    end
    step();
    ready_out = 1'b0;
    total++; if (count !== 3'd0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL flush_drain count=%0d valid_out=%b exp=0/0", count, valid_out);
    end
  endtask

  task automatic test_perf();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL perf_start got=%0d exp=0", stall_cnt); end
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 8'hE0;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 10; i++) step();
    total++; if (stall_cnt !== STALL_EXP) begin bad++; $display("FAIL perf_count got=%0d exp=%0d", stall_cnt, STALL_EXP); end
    flush     = 1'b1;
    ready_out = 1'b1;
    step();
    flush = 1'b0;
    step();
    ready_out = 1'b0;
    step();
    total++; if (stall_cnt !== STALL_EXP || valid_out !== 1'b0) begin
      bad++; $display("FAIL perf_flush stall_cnt=%0d valid_out=%b exp=%0d/0", stall_cnt, valid_out, STALL_EXP);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL perf_reset got=%0d exp=0", stall_cnt); end
  endtask

  // Scoreboard run against the DEPTH=8, DATAW=16 instance.
  task automatic test_random();
    logic        push;
    logic        pop;
    logic [15:0] d;
    exp_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      valid_in8  = 1'($urandom_range(0, 1));
      ready_out8 = 1'($urandom_range(0, 1));
      d          = 16'($urandom_range(0, 65535));
      data_in8   = d;
      push = valid_in8 && (exp_q.size() < 8);
      pop  = ready_out8 && (exp_q.size() > 0);
      total++; if (ready_in8 !== (exp_q.size() < 8) || valid_out8 !== (exp_q.size() > 0)) begin
        bad++; $display("FAIL rand_flags[%0d] ready_in=%b valid_out=%b exp=%b/%b", cyc, ready_in8, valid_out8, (exp_q.size() < 8), (exp_q.size() > 0));
      end
      if (pop) begin
        total++; if (data_out8 !== exp_q[0]) begin
          bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", cyc, data_out8, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (push) exp_q.push_back(d);
      step();
      total++; if (32'(count8) !== exp_q.size()) begin
        bad++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", cyc, count8, exp_q.size());
      end
    end
    valid_in8  = 1'b0;
    ready_out8 = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    flush      = 1'b0;
    valid_in   = 1'b0;
    data_in    = 8'h00;
    ready_out  = 1'b0;
    flush8     = 1'b0;
    valid_in8  = 1'b0;
    data_in8   = 16'h0000;
    ready_out8 = 1'b0;
    test_reset();
    test_back_to_back();
    test_fill_hold();
    test_full_pop();
    test_flush();
    test_perf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
